interrupt_ctrl: RTL and testbench
=================================

INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 5, number of interrupt sources (bit 0 = VBlank, 1 = LCDC, 2 = Timer, 3 = Serial, 4 = Joypad).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port a  input  16  bus address.
REQ-005 SHALL have port din  input  8  bus write data.
REQ-006 SHALL have port dout  output  8  bus read data, combinational.
REQ-007 SHALL have port rd  input  1  bus read strobe.
REQ-008 SHALL have port wr  input  1  bus write strobe.
REQ-009 SHALL have port int_req  input  NUM_SRC  peripheral request levels, held high until acknowledged.
REQ-010 SHALL have port int_ack  output  NUM_SRC  one-cycle acknowledge pulse per source.
REQ-011 SHALL have port cpu_int_pending  output  1  |(IF & IE); also used as HALT wake.
REQ-012 SHALL have port cpu_int_take  input  1  one-cycle CPU dispatch strobe.
REQ-013 SHALL have port cpu_int_vector  output  8  low byte of dispatch address.

Function
REQ-014 SHALL hold IF (FF0F, NUM_SRC bits) and IE (FFFF, 8 bits).
REQ-015 SHALL set IF[n] on a rising edge of int_req[n], detected against a registered copy req_q.
REQ-016 SHALL apply a bus write to FF0F as IF <= din[NUM_SRC-1:0]; a same-cycle rising edge SHALL win (bit set).
REQ-017 SHALL apply a bus write to FFFF as IE <= din.
REQ-018 SHALL return {3'b111, IF} for a read of FF0F, IE for FFFF, and 8'hFF for any other address.
REQ-019 SHALL assert cpu_int_pending combinationally as |(IF & IE[NUM_SRC-1:0]).
REQ-020 SHALL use a two-state FSM, IDLE and ACK; reset state IDLE.
REQ-021 In IDLE, cpu_int_take with a pending interrupt SHALL:
- select the lowest-index n with IF[n] & IE[n];
- clear IF[n], with priority over a same-cycle set of that bit;
- latch cpu_int_vector = 8'h40 + 8*n;
- pulse int_ack[n] high for exactly the next cycle;
- enter ACK.
REQ-022 In IDLE, cpu_int_take with nothing pending (IE cleared during dispatch) SHALL latch cpu_int_vector = 8'h00, clear nothing, and emit no ack.
REQ-023 ACK SHALL return to IDLE after one cycle unconditionally; cpu_int_take in ACK SHALL be ignored.
REQ-024 cpu_int_vector SHALL stay stable between takes.
REQ-025 int_ack SHALL be one-hot or zero at all times.
REQ-026 A source whose int_req stays high after ack SHALL NOT re-set IF without a new rising edge.

Reset
REQ-027 While rst_n is low: IF=0, IE=0, req_q=0, int_ack=0, cpu_int_vector=0, FSM=IDLE.
REQ-028 Assertion of rst_n mid-ACK SHALL drop int_ack immediately (asynchronously).

Structure
REQ-029 SHALL place register addresses (FF0F, FFFF), source-index constants, vector base 8'h40, and the FSM state encoding in a shared package.
REQ-030 SHALL implement priority selection as one sub-module, int_prio_enc (mask in, index + valid out, combinational).

Verification
REQ-031 Timer int_req rises, IE=8'h04, take -> IF[2] set next cycle; after take: vector 8'h50, int_ack=5'b00100 for one cycle, IF[2]=0.
REQ-032 IF=5'b10110, IE=8'hFF, take -> vector 8'h48, int_ack[1] only, IF=5'b10100.
REQ-033 Pending VBlank, IE written 8'h00 in the same cycle as take -> vector 8'h00, int_ack=0, IF[0] still set.
REQ-034 Write FF0F=8'h00 in the same cycle as a Serial rising edge -> IF=5'b01000; read FF0F -> 8'hE8.
REQ-035 int_req[4] held high across its ack -> IF[4] stays 0; dropping it and raising it again -> IF[4] set.
REQ-036 rst_n pulsed low during ACK -> int_ack=0 at once; after release, IF=0, IE=0, dout(FFFF)=8'h00.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// interrupt_ctrl_pkg
// Shared constants and types for the interrupt controller:
//   - bus addresses of the IF (flag) and IE (enable) registers
//   - source index constants (VBlank, LCDC, Timer, Serial, Joypad)
//   - dispatch vector base and the helper that turns an index into a vector
//   - dispatch FSM state encoding
// ----------------------------------------------------------------------------
package interrupt_ctrl_pkg;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam int SRC_VBLANK = 0;
  localparam int SRC_LCDC   = 1;
  localparam int SRC_TIMER  = 2;
  localparam int SRC_SERIAL = 3;
  localparam int SRC_JOYPAD = 4;

  localparam logic [7:0] VEC_BASE = 8'h40;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Each source owns an 8-byte slot above the vector base.
  function automatic logic [7:0] vector_for(input int unsigned idx);
    return VEC_BASE + 8'(idx << 3);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// ----------------------------------------------------------------------------
// int_prio_enc
// Combinational priority encoder: the lowest set bit of the mask wins.
// Ports:
//   mask  - candidate requests (IF & IE)
//   idx   - index of the lowest set bit (0 when nothing is set)
//   valid - high when any mask bit is set
// ----------------------------------------------------------------------------
module int_prio_enc #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest-numbered set bit is the last
  // assignment and therefore the one that sticks.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// ----------------------------------------------------------------------------
// interrupt_ctrl
// Game-boy style interrupt controller with IF (FF0F) and IE (FFFF) registers.
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   a, din, dout    - bus address, write data, combinational read data
//   rd, wr          - bus read / write strobes
//   int_req         - peripheral request levels (edge-detected into IF)
//   int_ack         - one-cycle acknowledge pulse to the dispatched source
//   cpu_int_pending - any enabled flag set; also the HALT wake signal
//   cpu_int_take    - CPU dispatch strobe
//   cpu_int_vector  - low byte of the dispatch address, held between takes
// ----------------------------------------------------------------------------
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  input  logic [NUM_SRC-1:0] int_req,
  output logic [NUM_SRC-1:0] int_ack,
  output logic               cpu_int_pending,
  input  logic               cpu_int_take,
  output logic [7:0]         cpu_int_vector
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] if_q, if_d;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_mask;
  logic [7:0]         ie_q, ie_eff;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               wr_if, wr_ie;
  logic               dispatch;

  assign wr_if = wr && (a == ADDR_IF);
  assign wr_ie = wr && (a == ADDR_IE);
  assign rise  = int_req & ~req_q;

  // A write to IE in the same cycle as a take already counts for selection,
  // so software disabling interrupts during dispatch yields the null vector.
  assign ie_eff = wr_ie ? din : ie_q;

  assign cpu_int_pending = |(if_q & ie_q[NUM_SRC-1:0]);

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio (
    .mask  (if_q & ie_eff[NUM_SRC-1:0]),
    .idx   (sel_idx),
    .valid (sel_valid)
  );

  // Dispatch FSM next-state: a take is only honoured in IDLE, and ACK lasts
  // exactly one cycle so a held take cannot dispatch twice back to back.
  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_int_take) begin
          dispatch = 1'b1;
          if (sel_valid) begin
            clr_mask = NUM_SRC'(1) << sel_idx;
            state_d  = ST_ACK;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // IF next value: bus write first, then new rising edges override it, and
  // the dispatch clear has the final word on its own bit.
  always_comb begin
    if_d = if_q;
    if (wr_if) if_d = din[NUM_SRC-1:0];
    if_d = (if_d | rise) & ~clr_mask;
  end

  // Bus read mux; unused high bits of IF read back as ones.
  always_comb begin
    dout = 8'hFF;
    if (rd) begin
      if (a == ADDR_IF)      dout[NUM_SRC-1:0] = if_q;
      else if (a == ADDR_IE) dout = ie_q;
    end
  end

  // Registers. The acknowledge is the clear mask delayed by one cycle, which
  // makes it one-hot (or zero) and drops asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      if_q           <= '0;
      ie_q           <= '0;
      req_q          <= '0;
      int_ack        <= '0;
      cpu_int_vector <= '0;
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      req_q   <= int_req;
      int_ack <= clr_mask;
      if (wr_ie) ie_q <= din;
      if (dispatch) cpu_int_vector <= sel_valid ? vector_for(32'(sel_idx)) : 8'h00;
    end
  end

endmodule

// File: tb/tb_interrupt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_interrupt_ctrl
// Directed self-checking bench for interrupt_ctrl.
// ----------------------------------------------------------------------------
module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic [4:0]  int_req;
  logic [4:0]  int_ack;
  logic        cpu_int_pending;
  logic        cpu_int_take;
  logic [7:0]  cpu_int_vector;

  int checks = 0;
  int errors = 0;

  interrupt_ctrl #(.NUM_SRC(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a               (a),
    .din             (din),
    .dout            (dout),
    .rd              (rd),
    .wr              (wr),
    .int_req         (int_req),
    .int_ack         (int_ack),
    .cpu_int_pending (cpu_int_pending),
    .cpu_int_take    (cpu_int_take),
    .cpu_int_vector  (cpu_int_vector)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic busRead(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    a  = addr;
    rd = 1'b1;
    #1;
    checkOutput(tag, dout, exp);
    rd = 1'b0;
  endtask

  task automatic applyStimulus();
    // Reset state
    rst_n = 1'b0; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
    int_req = 5'b0; cpu_int_take = 1'b0;
    #3;
    checkOutput("rst_ack", 8'(int_ack), 8'h00);
    checkOutput("rst_vec", cpu_int_vector, 8'h00);
    checkOutput("rst_pend", 8'(cpu_int_pending), 8'h00);
    busRead("rst_if", 16'hFF0F, 8'hE0);
    busRead("rst_ie", 16'hFFFF, 8'h00);
    busRead("other_addr", 16'hC000, 8'hFF);
    #2 rst_n = 1'b1;
    tick();

    // Timer dispatch
    busWrite(16'hFFFF, 8'h04);
    int_req = 5'b00100;
    tick();
    checkOutput("tmr_pend", 8'(cpu_int_pending), 8'h01);
    busRead("tmr_if_set", 16'hFF0F, 8'hE4);
    cpu_int_take = 1'b1;
    tick();
    cpu_int_take = 1'b0;
    checkOutput("tmr_vec", cpu_int_vector, 8'h50);
    checkOutput("tmr_ack", 8'(int_ack), 8'h04);
    busRead("tmr_if_clr", 16'hFF0F, 8'hE0);
    tick();
    checkOutput("tmr_ack_end", 8'(int_ack), 8'h00);
    checkOutput("tmr_vec_hold", cpu_int_vector, 8'h50);
    int_req = 5'b0;
    tick();

    // Priority: lowest enabled index wins, take held in ACK is ignored
    busWrite(16'hFF0F, 8'h16);
    busWrite(16'hFFFF, 8'hFF);
    busRead("prio_if", 16'hFF0F, 8'hF6);
    cpu_int_take = 1'b1;
    tick();
    checkOutput("prio_vec", cpu_int_vector, 8'h48);
    checkOutput("prio_ack", 8'(int_ack), 8'h02);
    tick();
    cpu_int_take = 1'b0;
    checkOutput("ackst_ack", 8'(int_ack), 8'h00);
    checkOutput("ackst_vec", cpu_int_vector, 8'h48);
    busRead("prio_if_after", 16'hFF0F, 8'hF4);

    // IE cleared in the same cycle as take
    busWrite(16'hFF0F, 8'h01);
    a = 16'hFFFF; din = 8'h00; wr = 1'b1; cpu_int_take = 1'b1;
    tick();
    wr = 1'b0; cpu_int_take = 1'b0;
    checkOutput("null_vec", cpu_int_vector, 8'h00);
    checkOutput("null_ack", 8'(int_ack), 8'h00);
    busRead("null_if", 16'hFF0F, 8'hE1);
    busRead("null_ie", 16'hFFFF, 8'h00);

    // IF write racing a Serial rising edge
    a = 16'hFF0F; din = 8'h00; wr = 1'b1; int_req = 5'b01000;
    tick();
    wr = 1'b0;
    busRead("race_if", 16'hFF0F, 8'hE8);

    // Joypad held high across its acknowledge
    busWrite(16'hFFFF, 8'hFF);
    busWrite(16'hFF0F, 8'h00);
    int_req = 5'b11000;
    tick();
    busRead("joy_if_set", 16'hFF0F, 8'hF0);
    cpu_int_take = 1'b1;
    tick();
    cpu_int_take = 1'b0;
    checkOutput("joy_vec", cpu_int_vector, 8'h60);
    checkOutput("joy_ack", 8'(int_ack), 8'h10);
    tick();
    tick();
    busRead("joy_held", 16'hFF0F, 8'hE0);
    int_req = 5'b01000;
    tick();
    int_req = 5'b11000;
    tick();
    busRead("joy_rearm", 16'hFF0F, 8'hF0);

    // Reset asserted while in ACK
    cpu_int_take = 1'b1;
    tick();
    cpu_int_take = 1'b0;
    checkOutput("pre_rst_ack", 8'(int_ack), 8'h10);
    #2 rst_n = 1'b0;
    int_req = 5'b0;
    #1;
    checkOutput("async_ack", 8'(int_ack), 8'h00);
    checkOutput("async_vec", cpu_int_vector, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    busRead("post_if", 16'hFF0F, 8'hE0);
    busRead("post_ie", 16'hFFFF, 8'h00);
    checkOutput("post_pend", 8'(cpu_int_pending), 8'h00);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
